// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared constants for the decode/execute pipeline register
package id_ex_pkg;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] NOP_ADDR  = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG  = 5'd0;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
endpackage

// File: rtl/id_ex_if.sv
// id_ex_if: decode-side, writeback, control and execute-side signals of the id/ex register
interface id_ex_if;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_used_i;
    logic        rs2_used_i;
    logic [4:0]  rd_addr_i;
    logic        rd_wen_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        wb_wen_i;
    logic        jump_en_i;
    logic        hold_flag_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;
    logic        valid_o;
    modport master (
        output inst_i, inst_addr_i, op1_i, op2_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        output rd_addr_i, rd_wen_i, wb_addr_i, wb_data_i, wb_wen_i, jump_en_i, hold_flag_i,
        input  inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o, valid_o
    );
    modport slave (
        input  inst_i, inst_addr_i, op1_i, op2_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        input  rd_addr_i, rd_wen_i, wb_addr_i, wb_data_i, wb_wen_i, jump_en_i, hold_flag_i,
        output inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o, valid_o
    );
endinterface

// File: rtl/id_ex_bypass.sv
// id_ex_bypass: replaces one operand with the same-cycle writeback value when the source register matches
module id_ex_bypass
    import id_ex_pkg::*;
(
    input  logic        i_wb_wen,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [4:0]  i_rs_addr,
    input  logic        i_rs_used,
    input  logic [31:0] i_op,
    output logic [31:0] o_op
);
    always_comb o_op = (i_wb_wen && i_wb_addr != ZERO_REG && i_wb_addr == i_rs_addr && i_rs_used) ? i_wb_data : i_op;
endmodule

// File: rtl/id_ex.sv
// id_ex: decode-to-execute pipeline register with flush, hold and writeback bypass of operands
module id_ex #(
    parameter logic [31:0] NOP_INST = id_ex_pkg::NOP_INST,
    parameter logic [31:0] NOP_ADDR = id_ex_pkg::NOP_ADDR
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    logic [31:0] r_inst, r_inst_addr, r_op1, r_op2;
    logic [4:0]  r_rd_addr, r_rs1_addr, r_rs2_addr;
    logic        r_rd_wen, r_valid, r_rs1_used, r_rs2_used;
    logic [4:0]  w_rs1_addr, w_rs2_addr;
    logic        w_rs1_used, w_rs2_used;
    logic [31:0] w_op1_in, w_op2_in, w_op1, w_op2;
    logic        w_hold;
    // One bypass per operand serves both paths: while held it watches the stored source, else the incoming one
    always_comb begin
        w_hold     = bus.hold_flag_i;
        w_rs1_addr = w_hold ? r_rs1_addr : bus.rs1_addr_i;
        w_rs2_addr = w_hold ? r_rs2_addr : bus.rs2_addr_i;
        w_rs1_used = w_hold ? (r_rs1_used && r_valid) : bus.rs1_used_i;
        w_rs2_used = w_hold ? (r_rs2_used && r_valid) : bus.rs2_used_i;
        w_op1_in   = w_hold ? r_op1 : bus.op1_i;
        w_op2_in   = w_hold ? r_op2 : bus.op2_i;
    end
    id_ex_bypass u_byp1 (
        .i_wb_wen (bus.wb_wen_i),
        .i_wb_addr(bus.wb_addr_i),
        .i_wb_data(bus.wb_data_i),
        .i_rs_addr(w_rs1_addr),
        .i_rs_used(w_rs1_used),
        .i_op     (w_op1_in),
        .o_op     (w_op1)
    );
    id_ex_bypass u_byp2 (
        .i_wb_wen (bus.wb_wen_i),
        .i_wb_addr(bus.wb_addr_i),
        .i_wb_data(bus.wb_data_i),
        .i_rs_addr(w_rs2_addr),
        .i_rs_used(w_rs2_used),
        .i_op     (w_op2_in),
        .o_op     (w_op2)
    );
    always_ff @(posedge clk) begin
        if (!rst || bus.jump_en_i) begin
            r_inst      <= NOP_INST;
            r_inst_addr <= NOP_ADDR;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rd_addr   <= '0;
            r_rd_wen    <= 1'b0;
            r_valid     <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rs1_used  <= 1'b0;
            r_rs2_used  <= 1'b0;
        end else if (w_hold) begin
            r_op1 <= w_op1;
            r_op2 <= w_op2;
        end else begin
            r_inst      <= bus.inst_i;
            r_inst_addr <= bus.inst_addr_i;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_rd_addr   <= bus.rd_addr_i;
            r_rd_wen    <= bus.rd_wen_i;
            r_valid     <= 1'b1;
            r_rs1_addr  <= bus.rs1_addr_i;
            r_rs2_addr  <= bus.rs2_addr_i;
            r_rs1_used  <= bus.rs1_used_i;
            r_rs2_used  <= bus.rs2_used_i;
        end
    end
    always_comb begin
        bus.inst_o      = r_inst;
        bus.inst_addr_o = r_inst_addr;
        bus.op1_o       = r_op1;
        bus.op2_o       = r_op2;
        bus.rd_addr_o   = r_rd_addr;
        bus.rd_wen_o    = r_rd_wen;
        bus.valid_o     = r_valid;
    end
endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- Pipeline register between the decode stage (id) and the execute stage (ex). It carries inst, inst_addr, op1, op2, rd_addr and rd_wen into ex with one cycle of latency.
- Applies the control-unit commands: flush on a taken jump, hold on a stall.
- Bypasses same-cycle register writebacks from ex into captured operands and into held operands, so ex never consumes a stale register value.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word loaded on reset/flush (addi x0,x0,0).
- NOP_ADDR, 32'h0000_0000, instruction address loaded on reset/flush.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- inst_i  in  32  instruction word from id.
- inst_addr_i  in  32  instruction address from id.
- op1_i  in  32  operand 1 from id (register value or immediate).
- op2_i  in  32  operand 2 from id.
- rs1_addr_i  in  5  source register 1 index from id.
- rs2_addr_i  in  5  source register 2 index from id.
- rs1_used_i  in  1  1 = op1_i is the value of rs1 (bypass eligible).
- rs2_used_i  in  1  1 = op2_i is the value of rs2.
- rd_addr_i  in  5  destination register index from id.
- rd_wen_i  in  1  destination write enable from id.
- wb_addr_i  in  5  ex writeback register index (ex rd_addr_o).
- wb_data_i  in  32  ex writeback data (ex rd_data_o).
- wb_wen_i  in  1  ex writeback enable (ex rd_wen_o).
- jump_en_i  in  1  flush request from ctrl (taken branch/jump).
- hold_flag_i  in  1  stall request from ctrl.
- inst_o  out  32  to ex.
- inst_addr_o  out  32  to ex.
- op1_o  out  32  to ex.
- op2_o  out  32  to ex.
- rd_addr_o  out  5  to ex.
- rd_wen_o  out  1  to ex.
- valid_o  out  1  1 = the register holds a real instruction; 0 = bubble.

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst; clock is clk.
- Reset (rst==0 at an edge) sets:
  - inst_o=NOP_INST, inst_addr_o=NOP_ADDR;
  - op1_o=op2_o=0, rd_addr_o=0, rd_wen_o=0, valid_o=0;
  - internal rs1/rs2 addr=0, used=0.
- Update priority per edge: reset > flush (jump_en_i) > hold (hold_flag_i) > load.
- Load:
  - All outputs capture their _i counterparts; valid_o=1.
  - Internal rs1/rs2 addr and used flags are captured too. Latency is exactly 1 cycle.
- Flush:
  - Same values as reset. jump_en_i together with hold_flag_i → flush wins.
  - A flush while held discards the held instruction.
- Hold: all registers retain their value, except for the held-bypass rule below.
- Capture bypass (load only):
  - If wb_wen_i && wb_addr_i!=0 && wb_addr_i==rs1_addr_i && rs1_used_i, then op1 captures wb_data_i instead of op1_i.
  - Same rule for rs2/op2. Both may hit in the same cycle.
- Held bypass (hold only):
  - If wb_wen_i && wb_addr_i!=0 && wb_addr_i==stored rs1 addr && stored rs1_used && valid_o, then op1_o updates to wb_data_i. Same rule for op2.
  - Other fields still hold.
- x0 is never bypassed: wb_addr_i==0 is ignored.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package/defines carries:
  - NOP encoding (32'h0000_0013) and zero-reg index;
  - the existing opcode constants; no new typedefs.
- One natural sub-module: id_ex_bypass, a combinational match/select for one operand. Instantiate it twice (rs1/op1, rs2/op2); it is used by both the capture path and the held path.

Test Plan:
- Reset: rst=0 for 2 cycles with arbitrary inputs → inst_o=0x00000013, op1_o=0, rd_wen_o=0, valid_o=0; rst=1, inst_i=0x00500093 (addi x1,x0,5), op1_i=0, op2_i=5 → next cycle inst_o=0x00500093, op2_o=5, rd_addr_o=1, rd_wen_o=1, valid_o=1.
- Flush: load inst_addr_i=0x10, then jump_en_i=1 → next cycle inst_o=0x00000013, rd_wen_o=0, valid_o=0; jump_en_i=1 with hold_flag_i=1 gives the same result.
- Hold: hold_flag_i=1 for 3 cycles while inst_i changes every cycle → outputs frozen at the prior instruction; release → the new inst_i appears 1 cycle later.
- Capture bypass: rs1_addr_i=3, rs1_used_i=1, op1_i=0x11, wb_wen_i=1, wb_addr_i=3, wb_data_i=0xAA → op1_o=0xAA. Repeat with wb_addr_i=0 → op1_o=0x11. Repeat with rs1_used_i=0 → op1_o=0x11.
- Held bypass: hold an instruction with stored rs2=5, rs2_used=1, op2_o=0x1; during the hold drive wb_wen_i=1, wb_addr_i=5, wb_data_i=0x77 → op2_o=0x77 next cycle, all other outputs unchanged.
- Reset mid-hold: hold active, rst=0 → next cycle outputs are NOP/zero, valid_o=0.
